// File: rtl/argmax_sequencer_if.sv
// Bundle of the score stream, encoder handshake and result port of
// argmax_sequencer. The sequencer connects through the slave modport, the
// surrounding logic (score source, encoder, consumer) through master.
// Optional ports exist only when ARGMAX_SEQ_PERF_EN is defined.
interface argmax_sequencer_if #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned DATA_W  = 32
);
  // score stream
  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_W-1:0]         s_data;
  logic                      s_last;
  // encoder side
  logic                      enc_valid;
  logic [N_CLASS*DATA_W-1:0] enc_d_in;
  logic                      enc_out_valid;
  logic [N_CLASS-1:0]        enc_d_out;
  // result port
  logic                      m_valid;
  logic                      m_ready;
  logic [N_CLASS-1:0]        m_onehot;
  logic [3:0]                m_index;
  logic                      m_error;
  logic                      busy;
`ifdef ARGMAX_SEQ_PERF_EN
  logic [15:0]               perf_done;
  logic [7:0]                perf_err;
`endif

`ifdef ARGMAX_SEQ_PERF_EN
  modport slave (
    input  s_valid, s_data, s_last, enc_out_valid, enc_d_out, m_ready,
    output s_ready, enc_valid, enc_d_in, m_valid, m_onehot, m_index, m_error, busy,
           perf_done, perf_err
  );
  modport master (
    output s_valid, s_data, s_last, enc_out_valid, enc_d_out, m_ready,
    input  s_ready, enc_valid, enc_d_in, m_valid, m_onehot, m_index, m_error, busy,
           perf_done, perf_err
  );
`else
  modport slave (
    input  s_valid, s_data, s_last, enc_out_valid, enc_d_out, m_ready,
    output s_ready, enc_valid, enc_d_in, m_valid, m_onehot, m_index, m_error, busy
  );
  modport master (
    output s_valid, s_data, s_last, enc_out_valid, enc_d_out, m_ready,
    input  s_ready, enc_valid, enc_d_in, m_valid, m_onehot, m_index, m_error, busy
  );
`endif
endinterface

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: collects N_CLASS serial scores into a vector, launches
// one operation of the one-hot argmax encoder, waits for its result (with a
// timeout) and presents one-hot + binary class index on a valid/ready port.
// Define ARGMAX_SEQ_PERF_EN to add the perf_done / perf_err result counters.
module argmax_sequencer #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  argmax_sequencer_if.slave bus
);

  localparam logic [3:0]         LAST_IDX    = 4'(N_CLASS - 1);
  localparam logic [3:0]         ERR_IDX     = 4'hF;
  localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [N_CLASS-1:0] ONE         = {{(N_CLASS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    COLLECT,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]        cnt;
  logic              fmt_err;
  logic [7:0]        timer;
  logic [DATA_W-1:0] vec [N_CLASS];

  logic [N_CLASS-1:0] m_onehot;
  logic [3:0]         m_index;
  logic               m_error;
  logic               m_valid;

  // FSM decode strobes
  logic s_ready;
  logic enc_valid;
  logic accept;
  logic vec_done;
  logic vec_short;
  logic enc_hit;
  logic enc_timeout;
  logic res_ack;

  // encoder result decode
  logic [3:0]         enc_idx;
  logic               onehot_ok;
  logic [N_CLASS-1:0] d_minus;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic and per-state handshake/strobe decode
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    enc_valid   = 1'b0;
    accept      = 1'b0;
    vec_done    = 1'b0;
    vec_short   = 1'b0;
    enc_hit     = 1'b0;
    enc_timeout = 1'b0;
    res_ack     = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          accept = 1'b1;
          if (cnt == LAST_IDX) begin
            // a full vector launches even without s_last; fmt_err flags it
            vec_done  = 1'b1;
            state_nxt = LAUNCH;
          end else if (bus.s_last) begin
            vec_short = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      LAUNCH: begin
        enc_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // a result arriving in the final timer cycle still wins over timeout
        if (bus.enc_out_valid) begin
          enc_hit   = 1'b1;
          state_nxt = HOLD;
        end else if (timer == TIMEOUT_CNT) begin
          enc_timeout = 1'b1;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          res_ack   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // one-hot check and binary index of the encoder output (bit 9 = class 0)
  always_comb begin
    enc_idx = ERR_IDX;
    d_minus = bus.enc_d_out - ONE;
    for (int unsigned i = 0; i < N_CLASS; i++) begin
      if (bus.enc_d_out[i]) begin
        enc_idx = 4'(N_CLASS - 1 - i);
      end
    end
    onehot_ok = (bus.enc_d_out != '0) && ((bus.enc_d_out & d_minus) == '0);
    if (!onehot_ok) begin
      enc_idx = ERR_IDX;
    end
  end

  // beat counter, score vector and sticky format error
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      fmt_err <= 1'b0;
      for (int unsigned i = 0; i < N_CLASS; i++) begin
        vec[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < N_CLASS; i++) begin
          if (cnt == 4'(i)) begin
            vec[i] <= bus.s_data;
          end
        end
        if (vec_done || vec_short) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        if (vec_done && !bus.s_last) begin
          fmt_err <= 1'b1;
        end
      end
      if (res_ack) begin
        fmt_err <= 1'b0;
      end
    end
  end

  // WAIT timer: holds the number of WAIT cycles including the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state == LAUNCH) begin
      timer <= 8'd1;
    end else if (state == WAIT && state_nxt == WAIT) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= '0;
    end
  end

  // result registers: loaded only on the HOLD entry edge
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_onehot <= '0;
      m_index  <= '0;
      m_error  <= 1'b0;
    end else if (vec_short || enc_timeout) begin
      m_valid  <= 1'b1;
      m_onehot <= '0;
      m_index  <= ERR_IDX;
      m_error  <= 1'b1;
    end else if (enc_hit) begin
      m_valid  <= 1'b1;
      m_onehot <= bus.enc_d_out;
      m_index  <= enc_idx;
      m_error  <= fmt_err | ~onehot_ok;
    end else if (res_ack) begin
      m_valid  <= 1'b0;
    end
  end

  // flatten the score vector, element 0 in the low bits
  always_comb begin
    bus.enc_d_in = '0;
    for (int unsigned i = 0; i < N_CLASS; i++) begin
      bus.enc_d_in[i*DATA_W +: DATA_W] = vec[i];
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.enc_valid = enc_valid;
  assign bus.m_valid   = m_valid;
  assign bus.m_onehot  = m_onehot;
  assign bus.m_index   = m_index;
  assign bus.m_error   = m_error;
  assign bus.busy      = !(state == COLLECT && cnt == '0);

`ifdef ARGMAX_SEQ_PERF_EN
  logic [15:0] perf_done;
  logic [7:0]  perf_err;

  // saturating counters of accepted good and error results
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_done <= '0;
      perf_err  <= '0;
    end else if (res_ack) begin
      if (m_error) begin
        if (perf_err != '1) begin
          perf_err <= perf_err + 8'd1;
        end
      end else if (perf_done != '1) begin
        perf_done <= perf_done + 16'd1;
      end
    end
  end

  assign bus.perf_done = perf_done;
  assign bus.perf_err  = perf_err;
`endif

endmodule
